// File: rtl/reg_dump_streamer_pkg.sv
// reg_dump_streamer_pkg: shared FSM state, register index type and default frame marker
package reg_dump_streamer_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, FETCH, SEND, DONE} state_e;
  typedef logic [4:0] reg_idx_t;
  localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;
endpackage

// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer: walks a register range through a read port and streams a header byte plus each value as 4 little-endian bytes
// Ports: clk/reset (async, active-high); start begins a dump; read_address/read_data form the
// combinational register-file read port; tx_data/tx_valid/tx_ready form the byte stream;
// busy is high while a frame is in progress; done pulses once after the last byte is accepted.
module reg_dump_streamer
  import reg_dump_streamer_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG = 31,
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  read_address,
  input  logic [31:0] read_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);
  localparam reg_idx_t FIRST = reg_idx_t'(FIRST_REG);
  localparam reg_idx_t LAST = reg_idx_t'(LAST_REG);
  if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
    $fatal(1, "reg_dump_streamer: register range must satisfy 0 <= FIRST_REG <= LAST_REG <= 31");
  end
  state_e state_q, state_d;
  reg_idx_t reg_idx_q, reg_idx_d;
  logic [1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] shift_q, shift_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      reg_idx_q <= FIRST;
      byte_cnt_q <= 2'd0;
      shift_q <= 32'h0;
    end else begin
      state_q <= state_d;
      reg_idx_q <= reg_idx_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q <= shift_d;
    end
  end
  // Bytes leave from shift_q[7:0]; the value is captured once per register in FETCH,
  // while read_address has already been stable for the whole cycle.
  always_comb begin
    state_d = state_q;
    reg_idx_d = reg_idx_q;
    byte_cnt_d = byte_cnt_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = HEADER;
        reg_idx_d = FIRST;
      end
      HEADER: if (tx_ready) state_d = FETCH;
      FETCH: begin
        shift_d = read_data;
        byte_cnt_d = 2'd0;
        state_d = SEND;
      end
      SEND: if (tx_ready) begin
        if (byte_cnt_q != 2'd3) begin
          shift_d = shift_q >> 8;
          byte_cnt_d = byte_cnt_q + 2'd1;
        end else if (reg_idx_q != LAST) begin
          reg_idx_d = reg_idx_q + 5'd1;
          state_d = FETCH;
        end else state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    tx_valid = (state_q == HEADER) || (state_q == SEND);
    tx_data = (state_q == HEADER) ? HEADER_BYTE : (state_q == SEND) ? shift_q[7:0] : 8'h00;
    busy = (state_q == HEADER) || (state_q == FETCH) || (state_q == SEND);
    done = state_q == DONE;
  end
  assign read_address = reg_idx_q;
endmodule

// File: tb/tb_reg_dump_streamer.sv
// tb_reg_dump_streamer: directed checks of framing, timing, backpressure, reset and parameter variants
module tb_reg_dump_streamer;
  logic clk = 0, reset;
  logic start[3], tx_ready[3], tx_valid[3], busy[3], done[3];
  logic [4:0] ra[3];
  logic [7:0] txd[3];
  logic [31:0] rf[32], ev[32];
  logic [7:0] got[3][512];
  int n_got[3] = '{0, 0, 0};
  int n_done[3] = '{0, 0, 0};
  int done_cyc[3] = '{0, 0, 0};
  int last_acc[3] = '{0, 0, 0};
  int cyc = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  reg_dump_streamer u0 (.clk(clk), .reset(reset), .start(start[0]), .read_address(ra[0]),
    .read_data(rf[ra[0]]), .tx_data(txd[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .busy(busy[0]), .done(done[0]));
  reg_dump_streamer #(.FIRST_REG(1), .LAST_REG(1)) u1 (.clk(clk), .reset(reset), .start(start[1]),
    .read_address(ra[1]), .read_data(rf[ra[1]]), .tx_data(txd[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .busy(busy[1]), .done(done[1]));
  reg_dump_streamer #(.FIRST_REG(2), .LAST_REG(3)) u2 (.clk(clk), .reset(reset), .start(start[2]),
    .read_address(ra[2]), .read_data(rf[ra[2]]), .tx_data(txd[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .busy(busy[2]), .done(done[2]));
  always @(negedge clk)
    for (int d = 0; d < 3; d++) begin
      if (tx_valid[d] && tx_ready[d] && n_got[d] < 512) begin
        got[d][n_got[d]] = txd[d];
        n_got[d]++;
        last_acc[d] = cyc;
      end
      if (done[d]) begin
        n_done[d]++;
        done_cyc[d] = cyc;
      end
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic preload();
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'h1000_0000 + i;
      ev[i] = 32'h1000_0000 + i;
    end
  endtask
  task automatic launch(input int d, output int t0);
    start[d] = 1;
    t0 = cyc;
    step();
    start[d] = 0;
  endtask
  task automatic wait_done(input int d, input int nd0, input int lim);
    for (int k = 0; k < lim && n_done[d] == nd0; k++) step();
    chk("done_timeout", 32'(n_done[d] != nd0), 1);
  endtask
  task automatic cmp_frame(input int d, input int base, input int fr, input int lr, input string tag);
    int n;
    logic [7:0] e;
    n = 1 + 4 * (lr - fr + 1);
    chk({tag, "_len"}, n_got[d] - base, n);
    for (int i = 0; i < n; i++) begin
      e = (i == 0) ? 8'hA5 : 8'(ev[fr + (i - 1) / 4] >> (8 * ((i - 1) % 4)));
      chk(tag, {24'h0, got[d][base + i]}, {24'h0, e});
    end
  endtask
  initial begin
    int t0, b0, nd0, bad;
    logic pv, pr;
    logic [7:0] pd;
    bit w;
    reset = 1;
    for (int d = 0; d < 3; d++) begin
      start[d] = 0;
      tx_ready[d] = 0;
    end
    preload();
    step();
    step();
    chk("rst_valid", tx_valid[0], 0);
    chk("rst_data", txd[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_addr0", ra[0], 0);
    chk("rst_addr1", ra[1], 1);
    chk("rst_addr2", ra[2], 2);
    reset = 0;
    step();
    // full dump, ready held high
    tx_ready[0] = 1;
    b0 = n_got[0];
    nd0 = n_done[0];
    bad = 0;
    launch(0, t0);
    for (int k = 1; k <= 170; k++) begin
      if (busy[0] !== (k <= 161)) bad++;
      step();
    end
    chk("a_busy_window", bad, 0);
    chk("a_done_count", n_done[0] - nd0, 1);
    chk("a_done_cycle", done_cyc[0] - t0, 162);
    cmp_frame(0, b0, 0, 31, "a_byte");
    // re-pulsed start and a write to r31 while r5 is being fetched
    preload();
    ev[31] = 32'h1234_5678;
    b0 = n_got[0];
    nd0 = n_done[0];
    w = 0;
    launch(0, t0);
    for (int k = 1; k < 300 && n_done[0] == nd0; k++) begin
      start[0] = (k == 3 || k == 50);
      if (ra[0] == 5'd5 && !w) begin
        rf[31] = 32'h1234_5678;
        w = 1;
      end
      step();
    end
    start[0] = 0;
    repeat (20) step();
    chk("b_write_done", 32'(w), 1);
    chk("b_done_count", n_done[0] - nd0, 1);
    chk("b_busy_after", busy[0], 0);
    cmp_frame(0, b0, 0, 31, "b_byte");
    // reset after 10 accepted bytes, then a fresh frame
    preload();
    b0 = n_got[0];
    launch(0, t0);
    for (int k = 0; k < 100 && n_got[0] - b0 < 10; k++) step();
    chk("c_partial", n_got[0] - b0, 10);
    reset = 1;
    #1;
    chk("c_rst_valid", tx_valid[0], 0);
    chk("c_rst_busy", busy[0], 0);
    chk("c_rst_addr", ra[0], 0);
    chk("c_rst_done", done[0], 0);
    step();
    step();
    reset = 0;
    step();
    b0 = n_got[0];
    nd0 = n_done[0];
    launch(0, t0);
    wait_done(0, nd0, 300);
    cmp_frame(0, b0, 0, 31, "c_byte");
    // start together with reset is dropped
    start[0] = 1;
    reset = 1;
    step();
    step();
    reset = 0;
    start[0] = 0;
    b0 = n_got[0];
    repeat (5) step();
    chk("s_busy", busy[0], 0);
    chk("s_no_bytes", n_got[0] - b0, 0);
    // single register with ready toggling
    rf[1] = 32'hDEAD_BEEF;
    ev[1] = 32'hDEAD_BEEF;
    tx_ready[1] = 1;
    b0 = n_got[1];
    nd0 = n_done[1];
    pv = 0;
    pr = 0;
    pd = 0;
    bad = 0;
    launch(1, t0);
    for (int k = 0; k < 100 && n_done[1] == nd0; k++) begin
      if (pv && !pr && (tx_valid[1] !== 1'b1 || txd[1] !== pd)) bad++;
      pv = tx_valid[1];
      pd = txd[1];
      pr = tx_ready[1];
      step();
      tx_ready[1] = ~tx_ready[1];
    end
    repeat (5) step();
    chk("d_stable", bad, 0);
    chk("d_done_count", n_done[1] - nd0, 1);
    chk("d_done_after_last", done_cyc[1] - last_acc[1], 1);
    cmp_frame(1, b0, 1, 1, "d_byte");
    // registers 2..3
    rf[2] = 32'h0;
    rf[3] = 32'hFFFF_FFFF;
    ev[2] = 32'h0;
    ev[3] = 32'hFFFF_FFFF;
    tx_ready[2] = 1;
    b0 = n_got[2];
    nd0 = n_done[2];
    launch(2, t0);
    wait_done(2, nd0, 50);
    chk("e_done_cycle", done_cyc[2] - t0, 12);
    cmp_frame(2, b0, 2, 3, "e_byte");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
